// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operations and datapath mux selects.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  typedef enum logic [1:0] {CLS_OTHER, CLS_R, CLS_I} op_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode for R-type and OP-IMM instructions,
// flagging funct7 encodings that are not part of RV32I.
module alu_decoder
  import control_pkg::*;
(
  input  op_class_t   cls,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [3:0]  alu_ctrl,
  output logic        illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct3)
      3'b000: alu_ctrl = (cls == CLS_R && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_ctrl = ALU_SLL;
      3'b010: alu_ctrl = ALU_SLT;
      3'b011: alu_ctrl = ALU_SLTU;
      3'b100: alu_ctrl = ALU_XOR;
      3'b101: alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: alu_ctrl = ALU_OR;
      3'b111: alu_ctrl = ALU_AND;
      default: alu_ctrl = ALU_ADD;
    endcase
    // OP-IMM only carries funct7 in the shift-amount forms; elsewhere it is immediate bits
    if (cls == CLS_R)
      illegal = !(funct7 == 7'b0000000 ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
    else if (cls == CLS_I && (funct3 == 3'b001 || funct3 == 3'b101))
      illegal = !(funct7 == 7'b0000000 || (funct3 == 3'b101 && funct7 == 7'b0100000));
    if (cls == CLS_OTHER)
      alu_ctrl = ALU_ADD;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: one state per cycle, 3-5 cycles per instruction plus memory waits;
// memory states hold every output stable until mem_req & mem_ready.
module multicycle_controller
  import control_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [2:0] AddressingControl,
  output logic       instr_done,
  output logic       illegal_instr
);

  state_t    state, next_state, decode_next;
  op_class_t op_cls;
  logic [3:0] alu_ctrl;
  logic      alu_illegal, op_illegal, taken;

  assign op_cls = (opcode == OP_R) ? CLS_R : (opcode == OP_I) ? CLS_I : CLS_OTHER;

  alu_decoder u_alu_decoder (
    .cls      (op_cls),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (alu_ctrl),
    .illegal  (alu_illegal)
  );

  always_comb begin
    decode_next = S_TRAP;
    op_illegal  = 1'b0;
    case (opcode)
      OP_LOAD:   begin decode_next = S_MEMADR; op_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11); end
      OP_STORE:  begin decode_next = S_MEMADR; op_illegal = (funct3 > 3'b010); end
      OP_R:      begin decode_next = S_EXECR;  op_illegal = alu_illegal; end
      OP_I:      begin decode_next = S_EXECI;  op_illegal = alu_illegal; end
      OP_BRANCH: begin decode_next = S_BRANCH; op_illegal = (funct3[2:1] == 2'b01); end
      OP_JAL:    decode_next = S_JAL;
      OP_JALR:   decode_next = S_JALR;
      OP_LUI:    decode_next = S_LUI;
      OP_AUIPC:  decode_next = S_AUIPC;
      default:   op_illegal = 1'b1;
    endcase
  end

  // Equal-type branches compare with SUB, the rest with SLT/SLTU; Zero means "condition false" for those
  assign taken = (funct3[0] ^ funct3[2]) ? !Zero : Zero;

  always_comb begin
    mem_req = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0;
    ALUSrcA = SRCA_PC; ALUSrcB = SRCB_RS2; ALUControl = ALU_ADD; ResultSrc = RES_ALUOUT;
    ImmSrc = IMM_I; AddressingControl = 3'b000; instr_done = 1'b0; illegal_instr = 1'b0;
    next_state = state;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALU;
        IRWrite = mem_ready; PCWrite = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM;
        if (opcode == OP_BRANCH) ImmSrc = IMM_B;
        else if (opcode == OP_JAL) ImmSrc = IMM_J;
        if (!op_illegal) next_state = decode_next;
        else if (TRAP_ON_ILLEGAL) next_state = S_TRAP;
        else begin next_state = S_FETCH; instr_done = 1'b1; end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM;
        ImmSrc = (opcode == OP_STORE) ? IMM_S : IMM_I;
        next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1; AdrSrc = 1'b1; AddressingControl = funct3;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA; RegWrite = 1'b1; AddressingControl = funct3; instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1; AdrSrc = 1'b1; MemWrite = 1'b1; AddressingControl = funct3;
        instr_done = mem_ready;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR:  begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUControl = alu_ctrl; next_state = S_ALUWB; end
      S_EXECI:  begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUControl = alu_ctrl; next_state = S_ALUWB; end
      S_LUI:    begin ALUSrcB = SRCB_IMM; ImmSrc = IMM_U; ALUControl = ALU_PASS_B; next_state = S_ALUWB; end
      S_AUIPC:  begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; ImmSrc = IMM_U; next_state = S_ALUWB; end
      S_ALUWB:  begin ResultSrc = RES_ALUOUT; RegWrite = 1'b1; instr_done = 1'b1; next_state = S_FETCH; end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ResultSrc = RES_ALUOUT;
        case (funct3[2:1])
          2'b10:   ALUControl = ALU_SLT;
          2'b11:   ALUControl = ALU_SLTU;
          default: ALUControl = ALU_SUB;
        endcase
        PCWrite = taken; instr_done = 1'b1; next_state = S_FETCH;
      end
      S_JAL:    begin ResultSrc = RES_ALUOUT; PCWrite = 1'b1; next_state = S_LINK; end
      S_JALR: begin
        ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ResultSrc = RES_ALU; PCWrite = 1'b1;
        next_state = S_LINK;
      end
      S_LINK: begin
        ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALU;
        RegWrite = 1'b1; instr_done = 1'b1; next_state = S_FETCH;
      end
      S_TRAP:   illegal_instr = 1'b1;
      default:  next_state = S_FETCH;
    endcase
    if (rst) begin
      mem_req = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0; instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle checks of the full controller output vector against hand-derived values.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, Zero, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, instr_done, illegal_instr;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc, AddressingControl;
  logic mem_req0, AdrSrc0, MemWrite0, IRWrite0, PCWrite0, RegWrite0, instr_done0, illegal_instr0;
  logic [1:0] ALUSrcA0, ALUSrcB0, ResultSrc0;
  logic [3:0] ALUControl0;
  logic [2:0] ImmSrc0, AddressingControl0;

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .AddressingControl(AddressingControl), .instr_done(instr_done), .illegal_instr(illegal_instr));

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req0), .AdrSrc(AdrSrc0), .MemWrite(MemWrite0),
    .IRWrite(IRWrite0), .PCWrite(PCWrite0), .RegWrite(RegWrite0), .ALUSrcA(ALUSrcA0),
    .ALUSrcB(ALUSrcB0), .ALUControl(ALUControl0), .ResultSrc(ResultSrc0), .ImmSrc(ImmSrc0),
    .AddressingControl(AddressingControl0), .instr_done(instr_done0), .illegal_instr(illegal_instr0));

  // {mem_req,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,A,B,ALUControl,ResultSrc,ImmSrc,AddrCtl,done,illegal}
  wire [23:0] obs  = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
                      ALUControl, ResultSrc, ImmSrc, AddressingControl, instr_done, illegal_instr};
  wire [23:0] obs0 = {mem_req0, AdrSrc0, MemWrite0, IRWrite0, PCWrite0, RegWrite0, ALUSrcA0, ALUSrcB0,
                      ALUControl0, ResultSrc0, ImmSrc0, AddressingControl0, instr_done0, illegal_instr0};

  localparam logic [23:0] V_FETCH_RDY  = 24'b1_0_0_1_1_0_00_10_0000_10_000_000_0_0;
  localparam logic [23:0] V_FETCH_WAIT = 24'b1_0_0_0_0_0_00_10_0000_10_000_000_0_0;
  localparam logic [23:0] V_FETCH_RST  = 24'b0_0_0_0_0_0_00_10_0000_10_000_000_0_0;
  localparam logic [23:0] V_DECODE     = 24'b0_0_0_0_0_0_01_01_0000_00_000_000_0_0;
  localparam logic [23:0] V_DECODE_ILL = 24'b0_0_0_0_0_0_01_01_0000_00_000_000_1_0;
  localparam logic [23:0] V_DECODE_B   = 24'b0_0_0_0_0_0_01_01_0000_00_010_000_0_0;
  localparam logic [23:0] V_DECODE_J   = 24'b0_0_0_0_0_0_01_01_0000_00_011_000_0_0;
  localparam logic [23:0] V_EXECR_ADD  = 24'b0_0_0_0_0_0_10_00_0000_00_000_000_0_0;
  localparam logic [23:0] V_ALUWB      = 24'b0_0_0_0_0_1_00_00_0000_00_000_000_1_0;
  localparam logic [23:0] V_MEMADR_L   = 24'b0_0_0_0_0_0_10_01_0000_00_000_000_0_0;
  localparam logic [23:0] V_MEMADR_S   = 24'b0_0_0_0_0_0_10_01_0000_00_001_000_0_0;
  localparam logic [23:0] V_MEMREAD_W  = 24'b1_1_0_0_0_0_00_00_0000_00_000_010_0_0;
  localparam logic [23:0] V_MEMWB_W    = 24'b0_0_0_0_0_1_00_00_0000_01_000_010_1_0;
  localparam logic [23:0] V_MEMWR_W    = 24'b1_1_1_0_0_0_00_00_0000_00_000_010_0_0;
  localparam logic [23:0] V_MEMWR_RST  = 24'b0_1_0_0_0_0_00_00_0000_00_000_010_0_0;
  localparam logic [23:0] V_LINK       = 24'b0_0_0_0_0_1_01_10_0000_10_000_000_1_0;
  localparam logic [23:0] V_TRAP       = 24'b0_0_0_0_0_0_00_00_0000_00_000_000_0_1;

  int checks = 0;
  int fails  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] ins);
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7 = ins[31:25];
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
    set_ir(32'h00000013);
    step();
    step();
    #4;
    checks++;
    if (obs !== V_FETCH_RST) begin fails++; $display("FAIL reset_forced: got %h expected %h", obs, V_FETCH_RST); end
    step();
    rst = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++;
      if (obs !== V_FETCH_WAIT) begin fails++; $display("FAIL fetch_hold c%0d: got %h expected %h", i, obs, V_FETCH_WAIT); end
      checks++;
      if (obs0 !== V_FETCH_WAIT) begin fails++; $display("FAIL fetch_hold_dut0 c%0d: got %h expected %h", i, obs0, V_FETCH_WAIT); end
      step();
    end
  endtask

  task automatic test_alu_reg();
    logic [23:0] exp [4];
    exp = '{V_FETCH_RDY, V_DECODE, V_EXECR_ADD, V_ALUWB};
    set_ir(32'h002081B3);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      checks++;
      if (obs !== exp[i]) begin fails++; $display("FAIL add c%0d: got %h expected %h", i, obs, exp[i]); end
      step();
    end
  endtask

  task automatic test_alu_imm();
    logic [31:0] ins [3];
    logic [23:0] ex3 [3];
    ins = '{32'h40315093, 32'hFFF00093, 32'h123450B7};
    ex3 = '{24'b0_0_0_0_0_0_10_01_0111_00_000_000_0_0,
            24'b0_0_0_0_0_0_10_01_0000_00_000_000_0_0,
            24'b0_0_0_0_0_0_00_01_1010_00_100_000_0_0};
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [23:0] exp [4];
      exp = '{V_FETCH_RDY, V_DECODE, ex3[k], V_ALUWB};
      set_ir(ins[k]);
      for (int i = 0; i < 4; i++) begin
        #4;
        checks++;
        if (obs !== exp[i]) begin fails++; $display("FAIL imm%0d c%0d: got %h expected %h", k, i, obs, exp[i]); end
        step();
      end
    end
  endtask

  task automatic test_load_wait();
    logic [23:0] exp [8];
    logic        rdy [8];
    exp = '{V_FETCH_RDY, V_DECODE, V_MEMADR_L, V_MEMREAD_W, V_MEMREAD_W, V_MEMREAD_W, V_MEMREAD_W, V_MEMWB_W};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    set_ir(32'h0080A283);
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #4;
      checks++;
      if (obs !== exp[i]) begin fails++; $display("FAIL lw c%0d: got %h expected %h", i, obs, exp[i]); end
      step();
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [4];
    logic        z   [4];
    logic [23:0] exb [4];
    ins = '{32'h00209463, 32'h00209463, 32'h0020F463, 32'h0020C463};
    z   = '{1'b0, 1'b1, 1'b1, 1'b0};
    exb = '{24'b0_0_0_0_1_0_10_00_0001_00_000_000_1_0,
            24'b0_0_0_0_0_0_10_00_0001_00_000_000_1_0,
            24'b0_0_0_0_1_0_10_00_1001_00_000_000_1_0,
            24'b0_0_0_0_1_0_10_00_1000_00_000_000_1_0};
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [23:0] exp [3];
      exp = '{V_FETCH_RDY, V_DECODE_B, exb[k]};
      set_ir(ins[k]);
      Zero = z[k];
      for (int i = 0; i < 3; i++) begin
        #4;
        checks++;
        if (obs !== exp[i]) begin fails++; $display("FAIL branch%0d c%0d: got %h expected %h", k, i, obs, exp[i]); end
        step();
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [31:0] ins [2];
    logic [23:0] exd [2];
    logic [23:0] exj [2];
    ins = '{32'h000100E7, 32'h000000EF};
    exd = '{V_DECODE, V_DECODE_J};
    exj = '{24'b0_0_0_0_1_0_10_01_0000_10_000_000_0_0,
            24'b0_0_0_0_1_0_00_00_0000_00_000_000_0_0};
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic [23:0] exp [4];
      exp = '{V_FETCH_RDY, exd[k], exj[k], V_LINK};
      set_ir(ins[k]);
      for (int i = 0; i < 4; i++) begin
        #4;
        checks++;
        if (obs !== exp[i]) begin fails++; $display("FAIL jump%0d c%0d: got %h expected %h", k, i, obs, exp[i]); end
        step();
      end
    end
  endtask

  task automatic test_illegal(input logic [31:0] ins, input int hold);
    set_ir(ins);
    mem_ready = 1'b1;
    #4;
    checks++;
    if (obs !== V_FETCH_RDY) begin fails++; $display("FAIL ill_fetch %h: got %h expected %h", ins, obs, V_FETCH_RDY); end
    step();
    mem_ready = 1'b0;
    #4;
    checks++;
    if (obs !== V_DECODE) begin fails++; $display("FAIL ill_decode %h: got %h expected %h", ins, obs, V_DECODE); end
    checks++;
    if (obs0 !== V_DECODE_ILL) begin fails++; $display("FAIL ill_decode_nop %h: got %h expected %h", ins, obs0, V_DECODE_ILL); end
    step();
    for (int i = 0; i < hold; i++) begin
      Zero = i[0];
      #4;
      checks++;
      if (obs !== V_TRAP) begin fails++; $display("FAIL trap_hold %h c%0d: got %h expected %h", ins, i, obs, V_TRAP); end
      step();
    end
    Zero = 1'b0;
    #4;
    checks++;
    if (obs0 !== V_FETCH_WAIT) begin fails++; $display("FAIL nop_refetch %h: got %h expected %h", ins, obs0, V_FETCH_WAIT); end
    step();
    rst = 1'b1;
    #4;
    checks++;
    if (obs !== V_TRAP) begin fails++; $display("FAIL trap_in_rst %h: got %h expected %h", ins, obs, V_TRAP); end
    step();
    rst = 1'b0;
    #4;
    checks++;
    if (obs !== V_FETCH_WAIT) begin fails++; $display("FAIL trap_exit %h: got %h expected %h", ins, obs, V_FETCH_WAIT); end
    step();
  endtask

  task automatic test_store_reset();
    logic [23:0] exp [4];
    logic        rdy [4];
    exp = '{V_FETCH_RDY, V_DECODE, V_MEMADR_S, V_MEMWR_W};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
    set_ir(32'h0020A223);
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[i];
      #4;
      checks++;
      if (obs !== exp[i]) begin fails++; $display("FAIL sw c%0d: got %h expected %h", i, obs, exp[i]); end
      step();
    end
    rst = 1'b1;
    #4;
    checks++;
    if (obs !== V_MEMWR_RST) begin fails++; $display("FAIL sw_rst_mid: got %h expected %h", obs, V_MEMWR_RST); end
    step();
    rst = 1'b0;
    #4;
    checks++;
    if (obs !== V_FETCH_WAIT) begin fails++; $display("FAIL sw_after_rst: got %h expected %h", obs, V_FETCH_WAIT); end
    step();
  endtask

  initial begin
    test_reset();
    test_alu_reg();
    test_alu_imm();
    test_load_wait();
    test_branch();
    test_jump();
    test_illegal(32'h402090B3, 2);
    test_illegal(32'h0000000F, 20);
    test_store_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
